minigpu_dispatcher: RTL and testbench
=====================================

# minigpu_dispatcher

Kernel-level block dispatcher upstream of the `miniGPU_core` instances. It accepts a kernel launch with a total thread count and splits it into blocks of up to `THREADS_PER_BLOCK` threads. Each block goes to a free core through that core's `start` / `block_id` / `thread_count` / `done` interface. It signals kernel completion once every block has been issued and every core has reported `done`.

## Interface

Parameters:
- `NUM_CORES`, default 2: number of cores driven.
- `THREADS_PER_BLOCK`, default 4: maximum threads per block; must fit in the 3-bit `thread_count`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `launch`  in  1  kernel launch request; sampled only in IDLE.
- `total_threads`  in  8  kernel thread count; latched on an accepted `launch`.
- `busy`  out  1  high in DISPATCH and DRAIN.
- `kernel_done`  out  1  one-cycle pulse when the kernel completes.
- `core_start`  out  NUM_CORES  per-core one-cycle start pulse.
- `core_block_id`  out  NUM_CORES*8  per-core block id; core i uses bits [8i+7:8i]. Held stable from `start` until the next issue to that core.
- `core_thread_count`  out  NUM_CORES*3  per-core thread count; core i uses [3i+2:3i]. Same hold rule as `core_block_id`.
- `core_done`  in  NUM_CORES  per-core level done from each core; may remain high from the previous block.

## Operation

Top FSM states: IDLE, DISPATCH, DRAIN, FINISH.

- **IDLE**
  - `launch`=1 latches `total_threads` into `remaining` and clears `next_block` to 0.
  - Goes to FINISH if `total_threads`=0, otherwise to DISPATCH.
- **DISPATCH**
  - At most one block is issued per cycle, to the lowest-index FREE core.
  - Issuing a block to core i:
    - Pulse `core_start[i]`.
    - Drive `core_block_id[i]` = `next_block`.
    - Drive `core_thread_count[i]` = min(`THREADS_PER_BLOCK`, `remaining`).
    - Increment `next_block` and decrease `remaining` by the issued count.
  - When `remaining` reaches 0, go to DRAIN.
- **DRAIN**
  - When all cores are FREE, go to FINISH.
- **FINISH**
  - `kernel_done`=1 for exactly this cycle, then go to IDLE.

Per-core tracker states: FREE, GUARD, RUN.

- **Issue:** FREE → GUARD; the guard counter is loaded with 2.
- **GUARD:** `core_done` is ignored. The counter decrements each cycle, and the tracker moves to RUN when it reaches 0. This masks a stale `done` left over from the previous block.
- **RUN:** `core_done`=1 sampled on an edge returns the tracker to FREE.
  - A core freed at edge E can be issued at edge E+1 at the earliest.

Arithmetic and widths:
- `remaining` is 8 bits; `next_block` is 8 bits.
- Maximum is 255 threads = 64 blocks (ids 0..63); the last block has count 3. No wrap-around is possible.

Boundary behaviour:
- `launch` outside IDLE is ignored; no queuing and no state change.
- `core_done` asserted while a core is FREE is ignored.
- A core freeing and a new issue in the same cycle: the freed core is not eligible until the next edge.
- Asserting `reset` at any time:
  - returns every FSM to IDLE/FREE immediately;
  - drops in-flight bookkeeping;
  - takes effect asynchronously, and no `kernel_done` follows.

## Timing

- Reset values:
  - `busy`=0, `kernel_done`=0.
  - `core_start`=0, `core_block_id`=0, `core_thread_count`=0.
  - FSM in IDLE, all trackers FREE, counters 0.
- All outputs are registered.
- An accepted `launch` at edge E0 enters DISPATCH, so `busy`=1 from E0.
  - The first `core_start[0]` is high in the cycle after E1.
  - The second block starts on `core_start[1]` after E2.
- `core_start` is never high for two consecutive cycles on the same core.
- Zero-thread launch at E0: FINISH after E0, `kernel_done` high for the cycle E0..E1, IDLE at E1.
- Last core going FREE at edge E:
  - DRAIN → FINISH at E+1;
  - `kernel_done` high E+1..E+2;
  - `busy` falls at E+1.

## Test plan

- **10 threads, 2 cores, each core raising done 5 cycles after its start:**
  - block 0 (count 4) → core0, block 1 (count 4) → core1;
  - block 2 (count 2) → core0 after core0 retires;
  - exactly one `kernel_done` pulse.
- **`total_threads`=0:** `kernel_done` pulse the cycle after launch; `core_start` never asserted; `busy` stays 0.
- **`total_threads`=4:** a single start on core0 with id 0 and count 4; core1 is never started; `kernel_done` follows core0's done.
- **`core_done` tied high, 255 threads:**
  - each core retires exactly 3 cycles after its start (guard honoured);
  - 64 starts in total;
  - the last start carries id 63 and count 3.
- **`launch` pulsed again mid-DISPATCH:** ignored; the block sequence and the total of starts are unchanged.
- **`reset` asserted after two blocks issued of a 12-thread kernel:** all outputs are 0 immediately and no `kernel_done`. A fresh 4-thread launch afterwards restarts at block id 0.

Source files
------------

// File: rtl/minigpu_dispatcher_if.sv
// Launch/completion handshake plus the per-core start/done bundle between the
// kernel dispatcher and the miniGPU cores.
interface minigpu_dispatcher_if #(
    parameter int unsigned NUM_CORES = 2
);
    localparam int unsigned ID_W  = 8;
    localparam int unsigned CNT_W = 3;

    logic                        launch;
    logic [7:0]                  total_threads;
    logic                        busy;
    logic                        kernel_done;
    logic [NUM_CORES-1:0]        core_start;
    logic [NUM_CORES*ID_W-1:0]   core_block_id;
    logic [NUM_CORES*CNT_W-1:0]  core_thread_count;
    logic [NUM_CORES-1:0]        core_done;

    // Host and cores side
    modport master (
        output launch, total_threads, core_done,
        input  busy, kernel_done, core_start, core_block_id, core_thread_count
    );

    // Dispatcher side
    modport slave (
        input  launch, total_threads, core_done,
        output busy, kernel_done, core_start, core_block_id, core_thread_count
    );
endinterface

// File: rtl/minigpu_dispatcher.sv
// Splits a kernel launch into blocks of up to THREADS_PER_BLOCK threads and
// issues them one per cycle to the lowest-index free core.
module minigpu_dispatcher #(
    parameter int unsigned NUM_CORES         = 2,
    parameter int unsigned THREADS_PER_BLOCK = 4
) (
    input logic                  clk,
    input logic                  reset,
    minigpu_dispatcher_if.slave  bus
);
    localparam int unsigned ID_W  = 8;
    localparam int unsigned CNT_W = 3;
    localparam int unsigned REM_W = 8;
    localparam logic [REM_W-1:0] TPB        = REM_W'(THREADS_PER_BLOCK);
    localparam logic [1:0]       GUARD_LOAD = 2'd2;

    typedef enum logic [1:0] {ST_IDLE, ST_DISPATCH, ST_DRAIN, ST_FINISH} state_e;
    typedef enum logic [1:0] {TR_FREE, TR_GUARD, TR_RUN} trk_e;

    state_e                     state_q, state_d;
    logic [REM_W-1:0]           remaining_q, remaining_d;
    logic [ID_W-1:0]            next_block_q, next_block_d;
    trk_e                       trk_q [NUM_CORES];
    trk_e                       trk_d [NUM_CORES];
    logic [1:0]                 guard_q [NUM_CORES];
    logic [1:0]                 guard_d [NUM_CORES];
    logic                       busy_q, busy_d;
    logic                       kernel_done_q, kernel_done_d;
    logic [NUM_CORES-1:0]       start_q, start_d;
    logic [NUM_CORES*ID_W-1:0]  block_id_q, block_id_d;
    logic [NUM_CORES*CNT_W-1:0] tcount_q, tcount_d;

    logic                       issue_ok;
    int unsigned                sel;
    logic                       all_free;
    logic [REM_W-1:0]           issue_cnt;

    // Next-state logic for the top FSM, the trackers and all registered outputs
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining_q;
        next_block_d  = next_block_q;
        trk_d         = trk_q;
        guard_d       = guard_q;
        start_d       = '0;
        block_id_d    = block_id_q;
        tcount_d      = tcount_q;
        issue_ok      = 1'b0;
        sel           = 0;
        all_free      = 1'b1;
        issue_cnt     = (remaining_q < TPB) ? remaining_q : TPB;

        // Decisions use registered tracker state, so a core freed this edge is not yet eligible
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
            if (trk_q[i] != TR_FREE) begin
                all_free = 1'b0;
            end else if (!issue_ok) begin
                issue_ok = 1'b1;
                sel      = i;
            end
            case (trk_q[i])
                TR_GUARD: begin
                    guard_d[i] = guard_q[i] - 2'd1;
                    if (guard_q[i] == 2'd1) trk_d[i] = TR_RUN;
                end
                TR_RUN:  if (bus.core_done[i]) trk_d[i] = TR_FREE;
                default: ;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                if (bus.launch) begin
                    remaining_d  = bus.total_threads;
                    next_block_d = '0;
                    state_d      = (bus.total_threads == '0) ? ST_FINISH : ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                if (issue_ok) begin
                    for (int unsigned i = 0; i < NUM_CORES; i++) begin
                        if (i == sel) begin
                            start_d[i]                    = 1'b1;
                            block_id_d[i*ID_W +: ID_W]    = next_block_q;
                            tcount_d[i*CNT_W +: CNT_W]    = CNT_W'(issue_cnt);
                            trk_d[i]                      = TR_GUARD;
                            guard_d[i]                    = GUARD_LOAD;
                        end
                    end
                    next_block_d = next_block_q + ID_W'(1);
                    remaining_d  = remaining_q - issue_cnt;
                    if (remaining_q == issue_cnt) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN:  if (all_free) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase

        busy_d        = (state_d == ST_DISPATCH) || (state_d == ST_DRAIN);
        kernel_done_d = (state_d == ST_FINISH);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            remaining_q   <= '0;
            next_block_q  <= '0;
            busy_q        <= 1'b0;
            kernel_done_q <= 1'b0;
            start_q       <= '0;
            block_id_q    <= '0;
            tcount_q      <= '0;
            for (int unsigned i = 0; i < NUM_CORES; i++) begin
                trk_q[i]   <= TR_FREE;
                guard_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            remaining_q   <= remaining_d;
            next_block_q  <= next_block_d;
            busy_q        <= busy_d;
            kernel_done_q <= kernel_done_d;
            start_q       <= start_d;
            block_id_q    <= block_id_d;
            tcount_q      <= tcount_d;
            trk_q         <= trk_d;
            guard_q       <= guard_d;
        end
    end

    assign bus.busy              = busy_q;
    assign bus.kernel_done       = kernel_done_q;
    assign bus.core_start        = start_q;
    assign bus.core_block_id     = block_id_q;
    assign bus.core_thread_count = tcount_q;

endmodule

// File: tb/tb_minigpu_dispatcher.sv
// Directed and randomized kernels checked against an issue-schedule model
// built from block counts and per-core retire times.
module tb_minigpu_dispatcher;
    localparam int NC  = 2;
    localparam int TPB = 4;

    logic clk = 1'b0;
    logic rst_n;

    initial forever #5 clk = ~clk;

    minigpu_dispatcher_if #(.NUM_CORES(NC)) bus();

    minigpu_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int e0, kd_exp;
    bit checking, relaunch_g, tied_g;
    int lat [256];
    int s_edge [NC];
    int s_lat  [NC];
    bit started[NC];
    int obs_edge[$], obs_core[$], obs_id[$], obs_cnt[$];
    int exp_edge[$], exp_core[$], exp_id[$], exp_cnt[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    // One clock: sample at the falling edge, then drive inputs for the next rising edge
    task automatic tick();
        int d;
        int idx;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < NC; i++) begin
            if (bus.core_start[i] === 1'b1) begin
                obs_edge.push_back(cyc);
                obs_core.push_back(i);
                obs_id.push_back(int'(bus.core_block_id[i*8 +: 8]));
                obs_cnt.push_back(int'(bus.core_thread_count[i*3 +: 3]));
                idx = obs_edge.size() - 1;
                if (idx > 255) idx = 255;
                s_edge[i]  = cyc;
                s_lat[i]   = lat[idx];
                started[i] = 1'b1;
            end
        end
        if (checking) begin
            check("busy", 32'(bus.busy), (cyc >= e0 && cyc < kd_exp) ? 32'd1 : 32'd0);
            check("kernel_done", 32'(bus.kernel_done), (cyc == kd_exp) ? 32'd1 : 32'd0);
        end
        // Done is stale-high for two cycles after a start, then rises lat cycles after it
        for (int i = 0; i < NC; i++) begin
            d = cyc + 1 - s_edge[i];
            if (started[i]) bus.core_done[i] = (d <= 2) || (d >= s_lat[i]);
            else            bus.core_done[i] = tied_g ? 1'b1 : 1'($urandom_range(0, 1));
        end
        bus.launch = relaunch_g && (cyc + 1 == e0 + 2);
        if (bus.launch) bus.total_threads = 8'($urandom_range(0, 255));
    endtask

    task automatic run_kernel(input string name, input int n, input int fixed_lat,
                              input bit tied, input bit relaunch);
        int nb, t, c, cnt, eff, maxf;
        int f[NC];
        int last_id[NC];
        int last_cnt[NC];
        tied_g     = tied;
        relaunch_g = relaunch;
        nb = (n + TPB - 1) / TPB;
        for (int b = 0; b < 256; b++) lat[b] = (fixed_lat >= 0) ? fixed_lat : $urandom_range(1, 7);
        exp_edge.delete(); exp_core.delete(); exp_id.delete(); exp_cnt.delete();
        e0   = cyc + 1;
        t    = e0;
        maxf = e0;
        for (int i = 0; i < NC; i++) begin
            f[i] = -1000;
            last_id[i] = -1;
            last_cnt[i] = 0;
        end
        // A core started at t retires at t+max(3,lat) and may be reused one edge later
        for (int b = 0; b < nb; b++) begin
            t++;
            c = -1;
            while (c < 0) begin
                for (int i = 0; i < NC; i++) if (c < 0 && f[i] < t) c = i;
                if (c < 0) t++;
            end
            cnt = n - b * TPB;
            if (cnt > TPB) cnt = TPB;
            exp_edge.push_back(t); exp_core.push_back(c);
            exp_id.push_back(b);   exp_cnt.push_back(cnt);
            eff  = (lat[b] < 3) ? 3 : lat[b];
            f[c] = t + eff;
            if (f[c] > maxf) maxf = f[c];
            last_id[c]  = b;
            last_cnt[c] = cnt;
        end
        kd_exp = (n == 0) ? e0 : maxf + 1;
        obs_edge.delete(); obs_core.delete(); obs_id.delete(); obs_cnt.delete();
        bus.total_threads = 8'(n);
        bus.launch        = 1'b1;
        checking          = 1'b1;
        while (cyc < kd_exp + 3) tick();
        checking   = 1'b0;
        relaunch_g = 1'b0;
        check({name, " starts"}, 32'(obs_edge.size()), 32'(nb));
        for (int b = 0; b < nb && b < obs_edge.size(); b++) begin
            check($sformatf("%s blk%0d edge", name, b), 32'(obs_edge[b] - e0), 32'(exp_edge[b] - e0));
            check($sformatf("%s blk%0d core", name, b), 32'(obs_core[b]), 32'(exp_core[b]));
            check($sformatf("%s blk%0d id", name, b),   32'(obs_id[b]),   32'(exp_id[b]));
            check($sformatf("%s blk%0d cnt", name, b),  32'(obs_cnt[b]),  32'(exp_cnt[b]));
        end
        for (int i = 0; i < NC; i++) begin
            if (last_id[i] >= 0) begin
                check($sformatf("%s hold id core%0d", name, i),  32'(bus.core_block_id[i*8 +: 8]), 32'(last_id[i]));
                check($sformatf("%s hold cnt core%0d", name, i), 32'(bus.core_thread_count[i*3 +: 3]), 32'(last_cnt[i]));
            end
        end
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.launch        = 1'b0;
        bus.total_threads = 8'd0;
        bus.core_done     = '0;
        checking          = 1'b0;
        relaunch_g        = 1'b0;
        tied_g            = 1'b0;
        e0                = 0;
        kd_exp            = 0;
        for (int i = 0; i < NC; i++) begin
            s_edge[i] = 0; s_lat[i] = 0; started[i] = 1'b0;
        end
        for (int b = 0; b < 256; b++) lat[b] = 3;

        tick(); tick();
        check("reset busy",        32'(bus.busy), 32'd0);
        check("reset kernel_done", 32'(bus.kernel_done), 32'd0);
        check("reset core_start",  32'(bus.core_start), 32'd0);
        check("reset block_id",    32'(bus.core_block_id), 32'd0);
        check("reset thread_cnt",  32'(bus.core_thread_count), 32'd0);
        rst_n = 1'b1;
        tick();

        run_kernel("t10", 10, 5, 1'b0, 1'b0);
        run_kernel("t0", 0, 3, 1'b0, 1'b0);
        run_kernel("t4", 4, -1, 1'b0, 1'b0);
        run_kernel("t255tied", 255, 0, 1'b1, 1'b0);
        if (obs_id.size() > 0) begin
            check("t255 last id",  32'(obs_id[obs_id.size()-1]), 32'd63);
            check("t255 last cnt", 32'(obs_cnt[obs_cnt.size()-1]), 32'd3);
        end
        run_kernel("relaunch", 22, -1, 1'b0, 1'b1);

        // Reset in the middle of a 12-thread kernel, after two issues
        tied_g = 1'b0;
        obs_edge.delete(); obs_core.delete(); obs_id.delete(); obs_cnt.delete();
        for (int b = 0; b < 256; b++) lat[b] = 4;
        bus.total_threads = 8'd12;
        bus.launch        = 1'b1;
        tick(); tick(); tick();
        check("rst12 starts before reset", 32'(obs_edge.size()), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("rst12 busy",        32'(bus.busy), 32'd0);
        check("rst12 kernel_done", 32'(bus.kernel_done), 32'd0);
        check("rst12 core_start",  32'(bus.core_start), 32'd0);
        check("rst12 block_id",    32'(bus.core_block_id), 32'd0);
        check("rst12 thread_cnt",  32'(bus.core_thread_count), 32'd0);
        repeat (4) begin
            tick();
            check("rst12 held kernel_done", 32'(bus.kernel_done), 32'd0);
            check("rst12 held core_start",  32'(bus.core_start), 32'd0);
        end
        rst_n = 1'b1;
        repeat (3) begin
            tick();
            check("rst12 after release kernel_done", 32'(bus.kernel_done), 32'd0);
        end
        run_kernel("post_rst4", 4, -1, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            run_kernel($sformatf("rand%0d", k), $urandom_range(1, 255), -1, 1'b0, 1'b0);
        end
        run_kernel("t1", 1, -1, 1'b0, 1'b0);
        run_kernel("t9", 9, 2, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
